// File: rtl/p2s_pkg.sv
// p2s_pkg -- definitions shared by the buffered parallel-to-serial converter.
//   p2s_state_e : FSM state encoding (IDLE, SHIFT)
//   eff_len()   : maps a requested length onto the number of bits actually
//                 sent; 0 or anything wider than the word means "whole word".
package p2s_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } p2s_state_e;

  function automatic int eff_len(input int len, input int n);
    return ((len == 0) || (len > n)) ? n : len;
  endfunction

endpackage

// File: rtl/p2s_hold_reg.sv
// p2s_hold_reg -- one-entry holding buffer (data + length + valid flag).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture load_data/load_len and mark the entry full
//   clear      : empty the entry (wins over load)
//   load_data  : N-bit word to capture
//   load_len   : LW-bit effective length to capture
//   data, len  : stored word and length
//   full       : entry holds a word
module p2s_hold_reg
  import p2s_pkg::*;
#(
  parameter int N  = 32,
  parameter int LW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic [N-1:0]  load_data,
  input  logic [LW-1:0] load_len,
  output logic [N-1:0]  data,
  output logic [LW-1:0] len,
  output logic          full
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      len  <= '0;
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      data <= load_data;
      len  <= load_len;
      full <= 1'b1;
    end
  end

endmodule

// File: rtl/p2s_buffered.sv
// p2s_buffered -- parallel-to-serial converter with a one-word holding buffer
// so a following word can be handed over back-to-back without an idle bit slot.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid    : parallel word offered
//   in_ready    : word can be accepted this cycle (holding buffer empty)
//   par_in, len : parallel word and number of bits to send (0 or >N = N)
//   enable      : bit-rate tick, one bit per enabled cycle while shifting
//   flush       : synchronous abort of the current and the buffered word
//   ser_out     : registered serial data
//   ser_valid   : ser_out updated this cycle
//   sof, eof    : first / last bit of a word, qualified by ser_valid
//   busy        : shifting or holding a buffered word
module p2s_buffered
  import p2s_pkg::*;
#(
  parameter int N         = 32,
  parameter int MSB_FIRST = 0,
  localparam int LW       = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  par_in,
  input  logic [LW-1:0] len,
  input  logic          enable,
  input  logic          flush,
  output logic          ser_out,
  output logic          ser_valid,
  output logic          sof,
  output logic          eof,
  output logic          busy
);

  p2s_state_e    state, state_next;
  logic [N-1:0]  sreg;
  logic [LW-1:0] scnt;
  logic          first_bit;

  logic [N-1:0]  hbuf;
  logic [LW-1:0] hlen;
  logic          hfull;

  logic          xfer;
  logic          fire;
  logic          last;
  logic          load_direct;
  logic          load_hold;
  logic          push_hold;
  logic [LW-1:0] len_eff;
  logic          edge_bit;
  logic [N-1:0]  sreg_shifted;

  // No bypass: a word can only be taken while the buffer is empty, even if
  // the buffer is being drained on this very edge.
  assign in_ready = !hfull;
  assign xfer     = in_valid && in_ready && !flush;
  assign len_eff  = LW'(eff_len(int'(len), N));
  assign busy     = (state == SHIFT) || hfull;

  assign edge_bit     = (MSB_FIRST != 0) ? sreg[N-1] : sreg[0];
  assign sreg_shifted = (MSB_FIRST != 0) ? {sreg[N-2:0], 1'b0}
                                         : {1'b0, sreg[N-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // On the last bit of a word the next word comes from the buffer if there
  // is one, otherwise straight from the input; either way SHIFT continues so
  // the next enable already carries the new word's first bit.
  always_comb begin
    state_next  = state;
    fire        = 1'b0;
    last        = 1'b0;
    load_direct = 1'b0;
    load_hold   = 1'b0;
    push_hold   = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            load_direct = 1'b1;
            state_next  = SHIFT;
          end
        end
        SHIFT: begin
          fire = enable;
          last = enable && (scnt == LW'(1));
          if (last && hfull)     load_hold   = 1'b1;
          else if (last && xfer) load_direct = 1'b1;
          else if (last)         state_next  = IDLE;
          if (xfer && !last)     push_hold   = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // A load on the eof edge overrides the shift of the finishing word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg      <= '0;
      scnt      <= '0;
      first_bit <= 1'b0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
    end else if (flush) begin
      scnt      <= '0;
      first_bit <= 1'b0;
      ser_valid <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
    end else begin
      ser_valid <= fire;
      sof       <= fire && first_bit;
      eof       <= last;
      if (fire) begin
        ser_out   <= edge_bit;
        sreg      <= sreg_shifted;
        scnt      <= scnt - LW'(1);
        first_bit <= 1'b0;
      end
      if (load_direct) begin
        sreg      <= par_in;
        scnt      <= len_eff;
        first_bit <= 1'b1;
      end else if (load_hold) begin
        sreg      <= hbuf;
        scnt      <= hlen;
        first_bit <= 1'b1;
      end
    end
  end

  p2s_hold_reg #(
    .N  (N),
    .LW (LW)
  ) hold (
    .clk       (clk),
    .rst       (rst),
    .load      (push_hold),
    .clear     (flush || load_hold),
    .load_data (par_in),
    .load_len  (len_eff),
    .data      (hbuf),
    .len       (hlen),
    .full      (hfull)
  );

endmodule

// File: doc/p2s_buffered.md
P2S_BUFFERED -- requirements
Module: p2s_buffered

Interface
REQ-001 SHALL have parameter N, default 32: parallel word width, 2..64.
REQ-002 SHALL have parameter MSB_FIRST, default 0: 0 = bit 0 first, 1 = bit N-1 first.
REQ-003 SHALL have localparam LW = $clog2(N+1): width of the length field and bit counter.
REQ-004 clk  input  1  rising-edge clock, sole clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  parallel word offered.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 par_in  input  N  parallel word.
REQ-009 len  input  LW  number of bits to send, sampled with par_in; 0 or >N means N.
REQ-010 enable  input  1  bit-rate tick; one bit advances per enable cycle.
REQ-011 flush  input  1  synchronous abort of the current word and the buffered word.
REQ-012 ser_out  output  1  serial data, registered.
REQ-013 ser_valid  output  1  one-cycle strobe: ser_out was updated this cycle.
REQ-014 sof  output  1  asserted with ser_valid on the first bit of a word.
REQ-015 eof  output  1  asserted with ser_valid on the last bit of a word.
REQ-016 busy  output  1  high while in SHIFT or while the holding buffer is full.

Function
REQ-017 SHALL contain a shift register (sreg, scnt) and a one-entry holding buffer (hbuf, hlen, hfull).
REQ-018 FSM states SHALL be IDLE and SHIFT.
REQ-019 in_ready SHALL equal !hfull, combinationally. There SHALL be no bypass when hbuf drains in the same cycle.
REQ-020 Handshake: a word SHALL transfer on a cycle with in_valid && in_ready. par_in and len SHALL be sampled on that edge only.
REQ-021 IDLE with a transfer: the word SHALL load sreg directly, set scnt = effective len, and move to SHIFT next cycle. hfull SHALL stay 0.
REQ-022 SHIFT with a transfer: the word SHALL go to hbuf and set hfull.
REQ-023 SHIFT with enable:
- ser_out <= current edge bit (bit 0, or bit N-1 when MSB_FIRST).
- sreg shifts toward that edge, zero fill.
- scnt decrements.
- ser_valid <= 1.
REQ-024 Cycles without enable, or outside SHIFT, SHALL have ser_valid = 0. ser_out SHALL hold its last value.
REQ-025 sof SHALL accompany the first enabled bit after a load. eof SHALL accompany the bit where scnt goes 1->0. Both SHALL be set for a 1-bit word.
REQ-026 On the eof edge:
- hfull=1: hbuf/hlen SHALL load into sreg/scnt, hfull SHALL clear, and the FSM SHALL stay in SHIFT. The next enable emits the new word's first bit, with no idle enable slot.
- hfull=0: the FSM SHALL return to IDLE.
REQ-027 Simultaneous eof and input transfer (hfull=0): the incoming word SHALL go directly to sreg and the FSM SHALL stay in SHIFT.
REQ-028 flush SHALL take priority over all other activity:
- FSM -> IDLE; hfull, scnt and ser_valid cleared.
- ser_out holds.
- A word offered the same cycle SHALL be dropped, and in_ready SHALL still read 1 if hfull was 0.
REQ-029 enable in IDLE SHALL be ignored.
REQ-030 Latency: a word accepted at edge t in IDLE SHALL have its first bit on the first enable edge at or after t+1.

Reset
REQ-031 rst SHALL asynchronously force:
- FSM = IDLE
- sreg, hbuf, scnt, hlen = 0
- hfull = 0
- ser_out, ser_valid, sof, eof = 0
REQ-032 After reset release: in_ready=1, busy=0. Reset mid-word SHALL discard all data, with no partial bits after release.

Structure
REQ-033 Shared package p2s_pkg SHALL hold the state enum (IDLE, SHIFT) and a helper function for effective length (0/>N -> N).
REQ-034 The holding buffer SHALL be a sub-module p2s_hold_reg (data+len register with valid flag). The FSM and shift register SHALL stay in the top.

Verification
REQ-035 N=8, LSB-first, enable=1 every cycle, word 0xA5, len=0 -> ser_out 1,0,1,0,0,1,0,1 on consecutive cycles; sof on bit 1, eof on bit 8, then IDLE.
REQ-036 N=8, MSB_FIRST=1, word 0xA5 accepted, then 0x3C accepted during shift -> 16 contiguous bits 10100101 00111100. in_ready low from the second accept until the handoff edge. No gap between eof and the next sof.
REQ-037 N=32, len=5, word 0x0000001B, enable every 3rd cycle -> 5 strobes carrying 1,1,0,1,1, spaced 3 cycles apart; eof on the 5th.
REQ-038 flush asserted after 3 of 8 bits with hbuf full -> next cycle IDLE, busy=0, in_ready=1, no further ser_valid.
REQ-039 rst pulsed asynchronously between clock edges mid-word -> outputs zero immediately. After release, no ser_valid until a new accept.
REQ-040 Randomised in_valid/enable with a scoreboard comparing the serial stream to accepted words and lens over 1000 words. Zero mismatches required.
